axis_pkt_gen: RTL and testbench

Parametrised AXI4-Stream packet generator, the successor to the fixed two-beat test source. It emits a run of packets with runtime-configurable beat count, packet count, inter-packet gap and data pattern (constant, incrementing, LFSR), under start/stop control. It sits at the head of stream datapaths as a stimulus/bring-up source and feeds any AXI4-Stream slave directly.

---
 rtl/axis_pkt_gen.sv | 214 +++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen
// AXI4-Stream packet generator used as a stimulus / bring-up source at the
// head of a stream datapath. A start pulse latches the cfg_* inputs and
// emits a run of packets. Each packet has a configurable number of beats
// and there is a configurable idle gap between packets. Data is a constant,
// an incrementing count or a 32-bit Galois LFSR. A stop pulse ends the run
// cleanly after the current packet.
//
// Ports
//   aclk, areset         clock, synchronous active-high reset
//   start, stop          one-cycle control pulses
//   cfg_len              beats per packet (0 behaves as 1)
//   cfg_npkts            packets per run (0 = run until stop)
//   cfg_gap              idle cycles between packets
//   cfg_mode             0 const, 1 incrementing, 2 LFSR, 3 as const
//   m_axis_*             AXI4-Stream master (tdata/tvalid/tready/tlast)
//   busy, done           run active / one-cycle end-of-run pulse
//   pkt_count            packets completed in the current or last run
module axis_pkt_gen #(
    parameter int          DATA_W    = 32,
    parameter int          LEN_W     = 16,
    parameter int          GAP_W     = 8,
    parameter logic [63:0] CONST_VAL = 64'h00000000DEADBEEF
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [15:0]       cfg_npkts,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [1:0]        cfg_mode,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Left-shifting Galois form of x^32+x^22+x^2+x+1, so seed 1 yields 1,2,4,8,...
    localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        lfsr_step = {cur[30:0], 1'b0} ^ (cur[31] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // Selects the beat data for a mode; the LFSR is zero-extended beyond 32 bits.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        mode,
                                                  input logic [DATA_W-1:0] inc,
                                                  input logic [31:0]       lfsr);
        logic [63:0] lfsr_ext;
        lfsr_ext = {32'h0000_0000, lfsr};
        case (mode)
            2'd1:    pattern = inc;
            2'd2:    pattern = lfsr_ext[DATA_W-1:0];
            default: pattern = CONST_VAL[DATA_W-1:0];
        endcase
    endfunction

    logic [1:0]        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [15:0]       r_npkts;
    logic [GAP_W-1:0]  r_gap;
    logic [1:0]        r_mode;
    logic [LEN_W-1:0]  r_beat;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [15:0]       r_pkt_count;
    logic [DATA_W-1:0] r_inc;
    logic [31:0]       r_lfsr;
    logic              r_stop_pend;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_busy;
    logic              r_done;

    logic [LEN_W-1:0]  w_len_eff;
    logic              w_accept;
    logic              w_stop_now;
    logic              w_run_done;
    logic [DATA_W-1:0] w_inc_next;
    logic [31:0]       w_lfsr_next;
    logic [DATA_W-1:0] w_data_next;

    // Derived per-cycle terms used by the state machine.
    always_comb begin
        w_len_eff   = r_len;
        w_run_done  = 1'b0;
        if (r_len == {LEN_W{1'b0}}) begin
            w_len_eff = LEN_W'(1);
        end else begin
            w_len_eff = r_len;
        end
        if ((r_npkts != 16'd0) && ((r_pkt_count + 16'd1) == r_npkts)) begin
            w_run_done = 1'b1;
        end else begin
            w_run_done = 1'b0;
        end
        w_accept    = r_tvalid & m_axis_tready;
        // A stop arriving on the same edge as the last beat still counts.
        w_stop_now  = r_stop_pend | stop;
        w_inc_next  = r_inc + DATA_W'(1);
        w_lfsr_next = lfsr_step(r_lfsr);
        w_data_next = pattern(r_mode, w_inc_next, w_lfsr_next);
    end

    // Packet/run state machine; all stream and status outputs are registered here.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_len       <= {LEN_W{1'b0}};
            r_npkts     <= 16'd0;
            r_gap       <= {GAP_W{1'b0}};
            r_mode      <= 2'd0;
            r_beat      <= {LEN_W{1'b0}};
            r_gap_cnt   <= {GAP_W{1'b0}};
            r_pkt_count <= 16'd0;
            r_inc       <= {DATA_W{1'b0}};
            r_lfsr      <= 32'h0000_0000;
            r_stop_pend <= 1'b0;
            r_tdata     <= {DATA_W{1'b0}};
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tvalid    <= 1'b0;
                    r_stop_pend <= 1'b0;
                    if (start) begin
                        r_len       <= cfg_len;
                        r_npkts     <= cfg_npkts;
                        r_gap       <= cfg_gap;
                        r_mode      <= cfg_mode;
                        r_beat      <= {LEN_W{1'b0}};
                        r_pkt_count <= 16'd0;
                        r_inc       <= {DATA_W{1'b0}};
                        r_lfsr      <= LFSR_SEED;
                        r_tdata     <= pattern(cfg_mode, {DATA_W{1'b0}}, LFSR_SEED);
                        r_tlast     <= (cfg_len <= LEN_W'(1));
                        r_tvalid    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    // Without a handshake tdata/tlast/tvalid simply hold.
                    if (w_accept) begin
                        r_inc   <= w_inc_next;
                        r_lfsr  <= w_lfsr_next;
                        r_tdata <= w_data_next;
                        if (r_tlast) begin
                            r_pkt_count <= r_pkt_count + 16'd1;
                            r_beat      <= {LEN_W{1'b0}};
                            r_tlast     <= (w_len_eff == LEN_W'(1));
                            if (w_run_done || w_stop_now) begin
                                r_state     <= ST_IDLE;
                                r_tvalid    <= 1'b0;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_stop_pend <= 1'b0;
                            end else if (r_gap != {GAP_W{1'b0}}) begin
                                r_state   <= ST_GAP;
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= r_gap - GAP_W'(1);
                            end
                        end else begin
                            r_beat  <= r_beat + LEN_W'(1);
                            r_tlast <= ((r_beat + LEN_W'(1)) == (w_len_eff - LEN_W'(1)));
                        end
                    end
                end
                ST_GAP: begin
                    if (w_stop_now) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                    end else if (r_gap_cnt == {GAP_W{1'b0}}) begin
                        r_state  <= ST_SEND;
                        r_tvalid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen
// Directed testbench for axis_pkt_gen. Each scenario is a task with its own
// inline comparisons. Inputs are driven and outputs are sampled on the
// falling clock edge.
module tb_axis_pkt_gen;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_len = 16'd0;
    logic [15:0] cfg_npkts = 16'd0;
    logic [7:0]  cfg_gap = 8'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_fail   = 0;

    axis_pkt_gen dut (
        .aclk         (aclk),
        .areset       (areset),
        .start        (start),
        .stop         (stop),
        .cfg_len      (cfg_len),
        .cfg_npkts    (cfg_npkts),
        .cfg_gap      (cfg_gap),
        .cfg_mode     (cfg_mode),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done),
        .pkt_count    (pkt_count)
    );

    always #5 aclk = ~aclk;

    // Pulse start across one rising edge; returns in the first cycle of the run.
    task automatic pulse_start(input logic [1:0] mode, input logic [15:0] len,
                               input logic [15:0] npk, input logic [7:0] gap);
        cfg_mode = mode; cfg_len = len; cfg_npkts = npk; cfg_gap = gap;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b last=%b busy=%b done=%b, required all 0",
                     m_axis_tvalid, m_axis_tlast, busy, done);
        end
        n_checks++;
        if (m_axis_tdata !== 32'd0 || pkt_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: tdata=%h pkt_count=%0d, required 0/0", m_axis_tdata, pkt_count);
        end
    endtask

    task automatic test_const;
        @(negedge aclk);
        m_axis_tready = 1'b1;
        pulse_start(2'd0, 16'd2, 16'd1, 8'd0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || m_axis_tdata !== 32'hDEADBEEF || m_axis_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL const_beat1: valid=%b busy=%b data=%h last=%b, required 1 1 deadbeef 0",
                     m_axis_tvalid, busy, m_axis_tdata, m_axis_tlast);
        end
        @(negedge aclk);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hDEADBEEF || m_axis_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL const_beat2: valid=%b data=%h last=%b, required 1 deadbeef 1",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        @(negedge aclk);
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL const_end: valid=%b done=%b busy=%b pkt=%0d, required 0 1 0 1",
                     m_axis_tvalid, done, busy, pkt_count);
        end
        @(negedge aclk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL const_done_pulse: done=%b, required 0", done);
        end
    endtask

    task automatic test_incr_gap;
        int  e = 0;
        int  low = 0;
        bit  fin = 0;
        m_axis_tready = 1'b1;
        pulse_start(2'd1, 16'd4, 16'd3, 8'd2);
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            if (done) begin
                fin = 1;
            end else if (m_axis_tvalid) begin
                n_checks++;
                if (m_axis_tdata !== 32'(e) || m_axis_tlast !== ((e % 4) == 3)) begin
                    n_fail++;
                    $display("FAIL incr_beat%0d: data=%0d last=%b, required %0d %b",
                             e, m_axis_tdata, m_axis_tlast, e, ((e % 4) == 3));
                end
                if (e == 4 || e == 8) begin
                    n_checks++;
                    if (low != 2) begin
                        n_fail++;
                        $display("FAIL incr_gap: low cycles=%0d, required 2", low);
                    end
                end
                low = 0;
                e++;
            end else begin
                low++;
            end
            if (!fin) @(negedge aclk);
        end
        n_checks++;
        if (!fin || e != 12 || pkt_count !== 16'd3 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_end: done_seen=%0d beats=%0d pkt=%0d valid=%b, required 1 12 3 0",
                     fin, e, pkt_count, m_axis_tvalid);
        end
    endtask

    task automatic test_lfsr_stall;
        logic [31:0] exp_d [5];
        int  i = 0;
        bit  fin = 0;
        exp_d[0] = 32'd1; exp_d[1] = 32'd2; exp_d[2] = 32'd4; exp_d[3] = 32'd8; exp_d[4] = 32'd16;
        m_axis_tready = 1'b0;
        pulse_start(2'd2, 16'd5, 16'd1, 8'd0);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (done) begin
                fin = 1;
            end else begin
                n_checks++;
                if (i > 4 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[i] || m_axis_tlast !== (i == 4)) begin
                    n_fail++;
                    $display("FAIL lfsr_beat%0d: valid=%b data=%h last=%b, required valid 1 last %b",
                             i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, (i == 4));
                end
                m_axis_tready = 1'($urandom_range(0, 1));
                if (m_axis_tvalid && m_axis_tready) i++;
                @(negedge aclk);
            end
        end
        m_axis_tready = 1'b1;
        n_checks++;
        if (!fin || i != 5 || pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL lfsr_end: done_seen=%0d beats=%0d pkt=%0d, required 1 5 1", fin, i, pkt_count);
        end
    endtask

    task automatic test_stop;
        int e = 0;
        int n_done = 0;
        m_axis_tready = 1'b1;
        pulse_start(2'd1, 16'd3, 16'd0, 8'd1);
        for (int cyc = 0; cyc < 40; cyc++) begin
            stop = 1'b0;
            if (done) n_done++;
            if (m_axis_tvalid) begin
                n_checks++;
                if (m_axis_tdata !== 32'(e) || m_axis_tlast !== ((e % 3) == 2)) begin
                    n_fail++;
                    $display("FAIL stop_beat%0d: data=%0d last=%b, required %0d %b",
                             e, m_axis_tdata, m_axis_tlast, e, ((e % 3) == 2));
                end
                if (e == 4) stop = 1'b1;
                e++;
            end
            @(negedge aclk);
        end
        stop = 1'b0;
        n_checks++;
        if (e != 6 || n_done != 1 || pkt_count !== 16'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_end: beats=%0d dones=%0d pkt=%0d busy=%b, required 6 1 2 0",
                     e, n_done, pkt_count, busy);
        end
    endtask

    task automatic test_areset_len0;
        int  e = 0;
        bit  fin = 0;
        m_axis_tready = 1'b1;
        pulse_start(2'd1, 16'd4, 16'd0, 8'd0);
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0 || m_axis_tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL areset_mid: valid=%b busy=%b pkt=%0d data=%0d, required 0 0 0 0",
                     m_axis_tvalid, busy, pkt_count, m_axis_tdata);
        end
        pulse_start(2'd1, 16'd0, 16'd3, 8'd0);
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            if (done) begin
                fin = 1;
            end else begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'(e) || m_axis_tlast !== 1'b1) begin
                    n_fail++;
                    $display("FAIL len0_beat%0d: valid=%b data=%0d last=%b, required 1 %0d 1",
                             e, m_axis_tvalid, m_axis_tdata, m_axis_tlast, e);
                end
                e++;
                @(negedge aclk);
            end
        end
        n_checks++;
        if (!fin || e != 3 || pkt_count !== 16'd3) begin
            n_fail++;
            $display("FAIL len0_end: done_seen=%0d beats=%0d pkt=%0d, required 1 3 3", fin, e, pkt_count);
        end
    endtask

    // A start in the done cycle must be accepted; a start while busy is ignored.
    task automatic test_back_to_back;
        m_axis_tready = 1'b1;
        pulse_start(2'd1, 16'd2, 16'd1, 8'd0);
        start = 1'b1;
        cfg_mode = 2'd0;
        @(negedge aclk);
        start = 1'b0;
        n_checks++;
        if (m_axis_tdata !== 32'd1 || m_axis_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: data=%0d last=%b, required 1 1", m_axis_tdata, m_axis_tlast);
        end
        @(negedge aclk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b, required 1", done);
        end
        pulse_start(2'd1, 16'd1, 16'd1, 8'd0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || m_axis_tdata !== 32'd0 || pkt_count !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: valid=%b busy=%b data=%0d pkt=%0d, required 1 1 0 0",
                     m_axis_tvalid, busy, m_axis_tdata, pkt_count);
        end
        @(negedge aclk);
        @(negedge aclk);
    endtask

    initial begin
        test_reset();
        test_const();
        test_incr_gap();
        test_lfsr_stall();
        test_stop();
        test_areset_len0();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
